// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient SRAM controller.
package fir_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned TAP_NUM_DEF    = 33;
    localparam int unsigned ADDR_WIDTH_DEF = 6;

    function automatic int unsigned halfTapOf(input int unsigned tapNum);
        return (tapNum + 1) / 2;
    endfunction

    localparam int unsigned HALF_TAP = halfTapOf(TAP_NUM_DEF);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} firState_e;

endpackage

// File: rtl/fir_tap_seq.sv
// Tap read sequencer: issues addresses 1..iLastTap one per cycle and delays
// the issue strobe/address by one cycle to line up with the SRAM read data.
module fir_tap_seq #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  iClk_12M,
    input  logic                  iRsn,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iLastTap,
    output logic                  oRdIss,
    output logic [ADDR_WIDTH-1:0] oRdAddr,
    output logic                  oLast,
    output logic                  oTapVld,
    output logic [ADDR_WIDTH-1:0] oTapIdx
);

    logic                  rdIssQ;
    logic [ADDR_WIDTH-1:0] rdAddrQ;
    logic                  tapVldQ;
    logic [ADDR_WIDTH-1:0] tapIdxQ;

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            rdIssQ  <= 1'b0;
            rdAddrQ <= '0;
            tapVldQ <= 1'b0;
            tapIdxQ <= '0;
        end else begin
            if (iStart) begin
                rdIssQ  <= 1'b1;
                rdAddrQ <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else if (rdIssQ) begin
                if (rdAddrQ == iLastTap) begin
                    rdIssQ <= 1'b0;
                end else begin
                    rdAddrQ <= rdAddrQ + 1'b1;
                end
            end
            // SRAM returns data one cycle after the address is issued.
            tapVldQ <= rdIssQ;
            tapIdxQ <= rdAddrQ;
        end
    end

    assign oRdIss  = rdIssQ;
    assign oRdAddr = rdAddrQ;
    assign oLast   = rdIssQ && (rdAddrQ == iLastTap);
    assign oTapVld = tapVldQ;
    assign oTapIdx = tapIdxQ;

endmodule

// File: rtl/fir_coef_sram_ctrl.sv
// Single-port coefficient SRAM arbiter: host writes vs per-sample tap sweeps.
// Define FIR_SYM_FOLD_EN to sweep/update only the first (TAP_NUM+1)/2 taps.
module fir_coef_sram_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned TAP_NUM    = TAP_NUM_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  iClk_12M,
    input  logic                  iRsn,
    input  logic                  iEnSample,
    input  logic                  iUpdReq,
    input  logic [ADDR_WIDTH-1:0] iUpdAddr,
    input  logic [DATA_WIDTH-1:0] iUpdData,
    output logic                  oUpdAck,
    output logic                  oUpdErr,
    output logic                  oCsnRam,
    output logic                  oWrnRam,
    output logic [ADDR_WIDTH-1:0] oAddrRam,
    output logic [DATA_WIDTH-1:0] oWrDtRam,
    input  logic [DATA_WIDTH-1:0] iRdDtRam,
    output logic [DATA_WIDTH-1:0] oCoef,
    output logic                  oTapVld,
    output logic [ADDR_WIDTH-1:0] oTapIdx,
    output logic                  oMacClr,
    output logic                  oMacDone,
    output logic                  oBusy,
    output logic                  oOverrun
);

`ifdef FIR_SYM_FOLD_EN
    localparam int unsigned LAST_TAP = halfTapOf(TAP_NUM);
`else
    localparam int unsigned LAST_TAP = TAP_NUM;
`endif
    localparam logic [ADDR_WIDTH-1:0] LastTapA = ADDR_WIDTH'(LAST_TAP);

    firState_e             stateQ;
    logic                  updAckQ;
    logic                  updErrQ;
    logic                  wrCsQ;
    logic [ADDR_WIDTH-1:0] wrAddrQ;
    logic [DATA_WIDTH-1:0] wrDtQ;
    logic                  macClrQ;
    logic                  macDoneQ;
    logic                  busyQ;
    logic                  overrunQ;

    logic                  seqStart;
    logic                  seqIss;
    logic [ADDR_WIDTH-1:0] seqAddr;
    logic                  seqLast;
    logic                  updInRange;

    assign seqStart   = (stateQ == IDLE) && iEnSample;
    assign updInRange = (iUpdAddr != '0) && (iUpdAddr <= LastTapA);

    fir_tap_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uTapSeq (
        .iClk_12M (iClk_12M),
        .iRsn     (iRsn),
        .iStart   (seqStart),
        .iLastTap (LastTapA),
        .oRdIss   (seqIss),
        .oRdAddr  (seqAddr),
        .oLast    (seqLast),
        .oTapVld  (oTapVld),
        .oTapIdx  (oTapIdx)
    );

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            stateQ   <= IDLE;
            updAckQ  <= 1'b0;
            updErrQ  <= 1'b0;
            wrCsQ    <= 1'b0;
            wrAddrQ  <= '0;
            wrDtQ    <= '0;
            macClrQ  <= 1'b0;
            macDoneQ <= 1'b0;
            busyQ    <= 1'b0;
            overrunQ <= 1'b0;
        end else begin
            updAckQ  <= 1'b0;
            updErrQ  <= 1'b0;
            wrCsQ    <= 1'b0;
            macClrQ  <= 1'b0;
            macDoneQ <= 1'b0;
            overrunQ <= iEnSample && (stateQ != IDLE);
            unique case (stateQ)
                IDLE: begin
                    // A sample strobe wins; a pending update waits for the next IDLE.
                    if (iEnSample) begin
                        stateQ  <= READ;
                        macClrQ <= 1'b1;
                        busyQ   <= 1'b1;
                    end else if (iUpdReq) begin
                        stateQ  <= WRITE;
                        busyQ   <= 1'b1;
                        updAckQ <= 1'b1;
                        updErrQ <= !updInRange;
                        wrCsQ   <= updInRange;
                        wrAddrQ <= iUpdAddr;
                        wrDtQ   <= iUpdData;
                    end
                end
                WRITE: begin
                    stateQ <= IDLE;
                    busyQ  <= 1'b0;
                end
                READ: begin
                    if (seqLast) begin
                        stateQ <= DRAIN;
                    end
                end
                DRAIN: begin
                    stateQ   <= DONE;
                    macDoneQ <= 1'b1;
                end
                DONE: begin
                    stateQ <= IDLE;
                    busyQ  <= 1'b0;
                end
                default: begin
                    stateQ <= IDLE;
                    busyQ  <= 1'b0;
                end
            endcase
        end
    end

    assign oUpdAck  = updAckQ;
    assign oUpdErr  = updErrQ;
    assign oCsnRam  = ~(wrCsQ | seqIss);
    assign oWrnRam  = ~wrCsQ;
    assign oAddrRam = wrCsQ ? wrAddrQ : seqAddr;
    assign oWrDtRam = wrDtQ;
    assign oCoef    = iRdDtRam;
    assign oMacClr  = macClrQ;
    assign oMacDone = macDoneQ;
    assign oBusy    = busyQ;
    assign oOverrun = overrunQ;

endmodule

// File: tb/tb_fir_coef_sram_ctrl.sv
// Directed self-checking bench for fir_coef_sram_ctrl with a 1-cycle SRAM model.
module tb_fir_coef_sram_ctrl;

    localparam int TAP = 33;
`ifdef FIR_SYM_FOLD_EN
    localparam int LAST = (TAP + 1) / 2;
`else
    localparam int LAST = TAP;
`endif

    logic        clk;
    logic        iRsn;
    logic        iEnSample;
    logic        iUpdReq;
    logic [5:0]  iUpdAddr;
    logic [15:0] iUpdData;
    logic        oUpdAck;
    logic        oUpdErr;
    logic        oCsnRam;
    logic        oWrnRam;
    logic [5:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [15:0] rdData = '0;
    logic [15:0] oCoef;
    logic        oTapVld;
    logic [5:0]  oTapIdx;
    logic        oMacClr;
    logic        oMacDone;
    logic        oBusy;
    logic        oOverrun;

    logic [15:0] mem   [0:63];
    logic [15:0] model [0:63];

    int checks = 0;
    int errors = 0;

    fir_coef_sram_ctrl dut (
        .iClk_12M  (clk),
        .iRsn      (iRsn),
        .iEnSample (iEnSample),
        .iUpdReq   (iUpdReq),
        .iUpdAddr  (iUpdAddr),
        .iUpdData  (iUpdData),
        .oUpdAck   (oUpdAck),
        .oUpdErr   (oUpdErr),
        .oCsnRam   (oCsnRam),
        .oWrnRam   (oWrnRam),
        .oAddrRam  (oAddrRam),
        .oWrDtRam  (oWrDtRam),
        .iRdDtRam  (rdData),
        .oCoef     (oCoef),
        .oTapVld   (oTapVld),
        .oTapIdx   (oTapIdx),
        .oMacClr   (oMacClr),
        .oMacDone  (oMacDone),
        .oBusy     (oBusy),
        .oOverrun  (oOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!oCsnRam) begin
            if (!oWrnRam) mem[oAddrRam] <= oWrDtRam;
            else          rdData <= mem[oAddrRam];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wrCoef(input logic [5:0] a, input logic [15:0] d, input logic expErr);
        bit seen;
        @(negedge clk);
        iUpdReq  = 1'b1;
        iUpdAddr = a;
        iUpdData = d;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (oUpdAck) seen = 1'b1;
        end
        iUpdReq = 1'b0;
        check("upd_ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("upd_err", 32'(oUpdErr), 32'(expErr));
            check("upd_csn", 32'(oCsnRam), 32'(expErr));
            if (!expErr) begin
                check("upd_wrn", 32'(oWrnRam), 32'd0);
                check("upd_addr", 32'(oAddrRam), 32'(a));
                model[a] = d;
            end
        end
    endtask

    // Pulses iEnSample and checks the full sweep; cycle 1 is the first negedge after the strobe edge.
    task automatic doSweep(input int reEnAt, input int expOvr);
        int nVld, nDone, nClr, nOvr, doneCyc, clrCyc, firstVld, lastVld, expIdx;
        nVld = 0; nDone = 0; nClr = 0; nOvr = 0;
        doneCyc = -1; clrCyc = -1; firstVld = -1; lastVld = -1; expIdx = 1;
        @(negedge clk);
        iEnSample = 1'b1;
        @(negedge clk);
        check("sweep_busy", 32'(oBusy), 32'd1);
        check("sweep_first_addr", 32'(oAddrRam), 32'd1);
        for (int cyc = 1; cyc <= LAST + 4; cyc++) begin
            iEnSample = (cyc == reEnAt);
            if (oTapVld) begin
                check("tap_idx", 32'(oTapIdx), 32'(expIdx));
                check("tap_coef", 32'(oCoef), 32'(model[expIdx]));
                if (firstVld < 0) firstVld = cyc;
                lastVld = cyc;
                expIdx++;
                nVld++;
            end
            if (oMacDone) begin nDone++; doneCyc = cyc; end
            if (oMacClr)  begin nClr++;  clrCyc = cyc;  end
            if (oOverrun) nOvr++;
            @(negedge clk);
        end
        iEnSample = 1'b0;
        check("sweep_nvld", 32'(nVld), 32'(LAST));
        check("sweep_first_vld", 32'(firstVld), 32'd2);
        check("sweep_last_vld", 32'(lastVld), 32'(LAST + 1));
        check("sweep_ndone", 32'(nDone), 32'd1);
        check("sweep_done_cyc", 32'(doneCyc), 32'(LAST + 2));
        check("sweep_nclr", 32'(nClr), 32'd1);
        check("sweep_clr_cyc", 32'(clrCyc), 32'd1);
        check("sweep_novr", 32'(nOvr), 32'(expOvr));
        check("sweep_idle", 32'(oBusy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int ackCyc, doneCyc, nVld;
        bit found;
        for (int i = 0; i < 64; i++) model[i] = '0;
        iRsn = 1'b0; iEnSample = 1'b0; iUpdReq = 1'b0; iUpdAddr = '0; iUpdData = '0;
        #1;
        check("rst_csn", 32'(oCsnRam), 32'd1);
        check("rst_wrn", 32'(oWrnRam), 32'd1);
        check("rst_ack", 32'(oUpdAck), 32'd0);
        check("rst_err", 32'(oUpdErr), 32'd0);
        check("rst_addr", 32'(oAddrRam), 32'd0);
        check("rst_wdt", 32'(oWrDtRam), 32'd0);
        check("rst_vld", 32'(oTapVld), 32'd0);
        check("rst_idx", 32'(oTapIdx), 32'd0);
        check("rst_clr", 32'(oMacClr), 32'd0);
        check("rst_done", 32'(oMacDone), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_ovr", 32'(oOverrun), 32'd0);
        @(negedge clk);
        iRsn = 1'b1;

        // Coefficient k*3 at each address; folded builds reject the upper half.
        for (int k = 1; k <= TAP; k++) wrCoef(6'(k), 16'(k * 3), k > LAST);
        doSweep(0, 0);

        // Reset while tap 10 is on the MAC.
        @(negedge clk);
        iEnSample = 1'b1;
        @(negedge clk);
        iEnSample = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (oTapVld && oTapIdx == 6'd10) found = 1'b1;
            else @(negedge clk);
        end
        check("midrst_reach_tap10", 32'(found), 32'd1);
        iRsn = 1'b0;
        #1;
        check("midrst_csn", 32'(oCsnRam), 32'd1);
        check("midrst_vld", 32'(oTapVld), 32'd0);
        check("midrst_busy", 32'(oBusy), 32'd0);
        @(negedge clk);
        iRsn = 1'b1;
        doSweep(0, 0);

        // Sample strobe and update request together: sweep first, then ack after one IDLE cycle.
        @(negedge clk);
        iEnSample = 1'b1;
        iUpdReq   = 1'b1;
        iUpdAddr  = 6'd5;
        iUpdData  = 16'h1234;
        @(negedge clk);
        iEnSample = 1'b0;
        ackCyc = -1; doneCyc = -1; nVld = 0;
        for (int cyc = 1; cyc <= LAST + 10; cyc++) begin
            if (oTapVld) begin
                nVld++;
                if (oTapIdx == 6'd5) check("conc_old_coef", 32'(oCoef), 32'd15);
            end
            if (oMacDone) doneCyc = cyc;
            if (oUpdAck && ackCyc < 0) begin
                ackCyc = cyc;
                check("conc_err", 32'(oUpdErr), 32'd0);
                iUpdReq = 1'b0;
            end
            @(negedge clk);
        end
        iUpdReq = 1'b0;
        model[5] = 16'h1234;
        check("conc_nvld", 32'(nVld), 32'(LAST));
        check("conc_done_cyc", 32'(doneCyc), 32'(LAST + 2));
        check("conc_ack_cyc", 32'(ackCyc), 32'(LAST + 4));
        doSweep(0, 0);

        // Re-strobe 5 cycles into a sweep.
        doSweep(5, 1);

        // Out-of-range updates leave the coefficient table untouched.
        wrCoef(6'd0, 16'hdead, 1'b1);
        wrCoef(6'(LAST + 1), 16'hbeef, 1'b1);
        wrCoef(6'd63, 16'h5a5a, 1'b1);
        doSweep(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_coef_sram_ctrl.md
Name: fir_coef_sram_ctrl

Overview:
- Controller for the single-port coefficient SRAM used by the direct-form FIR.
- Shares the one SRAM port between two requesters: host coefficient updates (writes) and per-sample tap sequencing (reads).
- On each sample strobe, reads taps 1..TAP_NUM in order and presents each coefficient to the MAC, aligned with a tap-valid strobe.
- Sits between the host config interface, the SRAM and the MAC datapath.

Parameters:
- DATA_WIDTH, 16, coefficient width; matches the SRAM data width.
- TAP_NUM, 33, number of taps; SRAM addresses 1..TAP_NUM are used and address 0 is unused.
- ADDR_WIDTH, 6, SRAM address width; must satisfy 2^ADDR_WIDTH > TAP_NUM.

Ports:
- iClk_12M  in  1  clock, rising edge.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample  in  1  one-cycle pulse: new input sample ready, start a tap sweep.
- iUpdReq  in  1  host write request; held high until oUpdAck.
- iUpdAddr  in  ADDR_WIDTH  coefficient address for the update.
- iUpdData  in  DATA_WIDTH  coefficient value for the update.
- oUpdAck  out  1  one-cycle pulse: update accepted.
- oUpdErr  out  1  one-cycle pulse with oUpdAck: address out of range, nothing written.
- oCsnRam  out  1  SRAM chip select, active low.
- oWrnRam  out  1  SRAM direction: 0 = write, 1 = read.
- oAddrRam  out  ADDR_WIDTH  SRAM address.
- oWrDtRam  out  DATA_WIDTH  SRAM write data.
- iRdDtRam  in  DATA_WIDTH  SRAM read data; registered, 1-cycle latency.
- oCoef  out  DATA_WIDTH  coefficient to the MAC (iRdDtRam passed through).
- oTapVld  out  1  oCoef valid for tap oTapIdx.
- oTapIdx  out  ADDR_WIDTH  tap index of the current oCoef.
- oMacClr  out  1  one-cycle pulse: clear the MAC accumulator, coincident with the first read issue.
- oMacDone  out  1  one-cycle pulse: sweep complete.
- oBusy  out  1  high whenever not IDLE.
- oOverrun  out  1  one-cycle pulse: iEnSample arrived while busy.

Behaviour:
- Reset is asynchronous, active low. Reset value of every output: oCsnRam=1, oWrnRam=1, all other outputs 0. The FSM returns to IDLE.
- Reset mid-sweep or mid-write aborts with no pending state retained.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - iEnSample=1 -> READ. It has priority over iUpdReq when both are high in the same cycle.
  - Otherwise iUpdReq=1 -> WRITE.
- WRITE (1 cycle):
  - In-range address (1..TAP_NUM): oCsnRam=0, oWrnRam=0, oAddrRam=iUpdAddr, oWrDtRam=iUpdData, oUpdAck=1.
  - Address 0 or >TAP_NUM: oCsnRam=1, oUpdAck=1, oUpdErr=1.
  - Next state: IDLE. The host must drop iUpdReq the cycle after ack; if it stays high, it is treated as a new request.
- READ:
  - Internal counter k runs 1..TAP_NUM, one per cycle.
  - Each cycle: oCsnRam=0, oWrnRam=1, oAddrRam=k.
  - oMacClr=1 during the k=1 cycle only.
  - After k=TAP_NUM -> DRAIN.
- Read alignment: oTapVld and oTapIdx are registered copies of the read-issue strobe and address, delayed 1 cycle. oCoef=iRdDtRam is therefore valid whenever oTapVld=1.
- DRAIN (1 cycle): oCsnRam=1; the last tap (TAP_NUM) is valid this cycle. Next state: DONE.
- DONE (1 cycle): oMacDone=1, then -> IDLE.
- Timing: iEnSample sampled at edge T:
  - reads issue T+1..T+TAP_NUM;
  - oTapVld high T+2..T+TAP_NUM+1;
  - oMacDone at T+TAP_NUM+2.
  - Minimum sample spacing is TAP_NUM+3 cycles.
- iEnSample in any non-IDLE state: the sample is dropped, oOverrun pulses, and the sweep continues unaffected.
- iUpdReq during a sweep is stalled (no ack) until IDLE. Worst-case update latency is TAP_NUM+3 cycles.
- oCsnRam=1 in IDLE and DRAIN/DONE; SRAM outputs are don't-care when deselected.
- No arithmetic on data; the controller never modifies coefficient values.

Optional Feature:
- FIR_SYM_FOLD_EN defined:
  - Symmetric-coefficient mode. The sweep reads only taps 1..(TAP_NUM+1)/2 (17 for the default).
  - oMacDone arrives at T+(TAP_NUM+1)/2+2.
  - Minimum sample spacing becomes (TAP_NUM+1)/2+3.
  - Update range is restricted to 1..(TAP_NUM+1)/2; addresses above that set oUpdErr.
- Undefined: full TAP_NUM sweep as described above.

Decomposition:
- Shared package fir_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - default DATA_WIDTH, TAP_NUM, ADDR_WIDTH;
  - derived constant HALF_TAP=(TAP_NUM+1)/2.
- One natural sub-module, fir_tap_seq: tap counter plus 1-cycle valid/index alignment pipe. The FSM and arbitration stay in the top.

Test Plan:
- Reset mid-sweep at tap 10: oCsnRam=1, oTapVld=0, oBusy=0 immediately; a later iEnSample starts a fresh sweep from addr 1.
- Write coef k*3 to addr k=1..33 via iUpdReq, then pulse iEnSample:
  - oTapVld high 33 consecutive cycles with oTapIdx 1..33 and oCoef 3..99;
  - oMacClr 1 cycle before the first oTapVld;
  - oMacDone 35 cycles after iEnSample.
- iEnSample and iUpdReq high in the same IDLE cycle: the sweep runs first; oUpdAck arrives exactly after oMacDone (IDLE cycle); the new coef is seen on the next sweep.
- iEnSample re-pulsed 5 cycles into a sweep: oOverrun pulses once; exactly 33 oTapVld and one oMacDone for the original sweep.
- iUpdAddr=0 and iUpdAddr=34: oUpdAck=1 and oUpdErr=1, oCsnRam stays 1; a following sweep shows unchanged coefs.
- FIR_SYM_FOLD_EN build: 17 oTapVld (idx 1..17), oMacDone at T+19; write to addr 18 -> oUpdErr=1.
